// File: rtl/ahb_lite_interconnect_pkg.sv
// Shared AHB-Lite encodings, default address map and default-slave state codes
// used by the interconnect and its default slave.
package ahb_lite_interconnect_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [31:0] NOMAP_DATA_DEFAULT = 32'hDEADBEEF;

    // Slot order: 0 rom, 1 ram, 2 gpio, 3 uart.
    localparam logic [127:0] DEFAULT_BASE_ADDRS =
        {32'h51000000, 32'h50000000, 32'h20000000, 32'h00000000};
    localparam logic [127:0] DEFAULT_ADDR_MASKS = {4{32'hFF000000}};

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StErr1 = 2'd1;
    localparam logic [1:0] StErr2 = 2'd2;

    function automatic logic trans_active(input logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_lite_interconnect_default_slave.sv
// Default slave: answers active transfers to unmapped addresses with the
// two-cycle AHB ERROR response.
module ahb_lite_interconnect_default_slave
    import ahb_lite_interconnect_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    output logic hreadyout_o,
    output logic hresp_o
);

    logic [1:0] state_q, state_d;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_i) state_d = StErr1;
            StErr1:  state_d = StErr2;
            StErr2:  state_d = start_i ? StErr1 : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    assign hreadyout_o = (state_q != StErr1);
    assign hresp_o     = (state_q == StIdle) ? HRESP_OKAY : HRESP_ERROR;

endmodule

// File: rtl/ahb_lite_interconnect.sv
// AHB-Lite decoder and response mux with a built-in default slave and
// bus-error capture (address, saturating count, one-cycle interrupt pulse).
module ahb_lite_interconnect
    import ahb_lite_interconnect_pkg::*;
#(
    parameter int unsigned             NSLAVES    = 4,
    parameter logic [NSLAVES*32-1:0]   BASE_ADDRS = DEFAULT_BASE_ADDRS,
    parameter logic [NSLAVES*32-1:0]   ADDR_MASKS = DEFAULT_ADDR_MASKS,
    parameter logic [31:0]             NOMAP_DATA = NOMAP_DATA_DEFAULT,
    parameter int unsigned             ERRCNT_W   = 8
) (
    input  logic                    HCLK,
    input  logic                    resetHW,
    input  logic [31:0]             HADDR,
    input  logic [1:0]              HTRANS,
    output logic [NSLAVES-1:0]      HSEL,
    input  logic [NSLAVES*32-1:0]   HRDATA_S,
    input  logic [NSLAVES-1:0]      HREADYOUT_S,
    input  logic [NSLAVES-1:0]      HRESP_S,
    output logic [31:0]             HRDATA,
    output logic                    HREADY,
    output logic                    HRESP,
    input  logic                    err_clear,
    output logic [31:0]             err_addr,
    output logic [ERRCNT_W-1:0]     err_count,
    output logic                    err_irq
);

    localparam int unsigned IDXW = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;

    logic [NSLAVES-1:0] match;
    logic [31:0]        rdata_s [NSLAVES];
    logic               hit;
    logic [IDXW-1:0]    hit_idx;

    for (genvar g = 0; g < NSLAVES; g++) begin : g_dec
        assign match[g]   = (HADDR & ADDR_MASKS[32*g +: 32]) == BASE_ADDRS[32*g +: 32];
        assign rdata_s[g] = HRDATA_S[32*g +: 32];
    end

    // Lowest index wins so HSEL stays one-hot when windows overlap.
    always_comb begin
        HSEL    = '0;
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < NSLAVES; i++) begin
            if (match[i] && !hit) begin
                hit     = 1'b1;
                hit_idx = IDXW'(i);
                HSEL[i] = 1'b1;
            end
        end
    end

    logic            own_slave_q;
    logic [IDXW-1:0] owner_q;
    logic [31:0]     addr_q;

    always_ff @(posedge HCLK or posedge resetHW) begin
        if (resetHW) begin
            own_slave_q <= 1'b0;
            owner_q     <= '0;
            addr_q      <= '0;
        end else if (HREADY) begin
            own_slave_q <= hit;
            owner_q     <= hit_idx;
            addr_q      <= HADDR;
        end
    end

    logic ds_start, ds_hreadyout, ds_hresp;

    assign ds_start = HREADY && !hit && trans_active(HTRANS);

    ahb_lite_interconnect_default_slave u_default_slave (
        .clk_i       (HCLK),
        .rst_i       (resetHW),
        .start_i     (ds_start),
        .hreadyout_o (ds_hreadyout),
        .hresp_o     (ds_hresp)
    );

    always_comb begin
        HRDATA = NOMAP_DATA;
        HREADY = ds_hreadyout;
        HRESP  = ds_hresp;
        if (own_slave_q) begin
            HRDATA = rdata_s[owner_q];
            HREADY = HREADYOUT_S[owner_q];
            HRESP  = HRESP_S[owner_q];
        end
    end

    // err_seen_q masks repeat counting if a slave stretches its first error cycle.
    logic                err_seen_q, err_event;
    logic [31:0]         err_addr_q;
    logic [ERRCNT_W-1:0] err_count_q, err_count_d;
    logic                err_irq_q;

    assign err_event = HRESP && !HREADY && !err_seen_q;

    always_comb begin
        err_count_d = err_count_q;
        if (err_clear) begin
            err_count_d = err_event ? ERRCNT_W'(1) : '0;
        end else if (err_event && !(&err_count_q)) begin
            err_count_d = err_count_q + ERRCNT_W'(1);
        end
    end

    always_ff @(posedge HCLK or posedge resetHW) begin
        if (resetHW) begin
            err_seen_q  <= 1'b0;
            err_addr_q  <= '0;
            err_count_q <= '0;
            err_irq_q   <= 1'b0;
        end else begin
            err_seen_q  <= HRESP && !HREADY;
            err_count_q <= err_count_d;
            err_irq_q   <= err_event;
            if (err_event) begin
                err_addr_q <= addr_q;
            end
        end
    end

    assign err_addr  = err_addr_q;
    assign err_count = err_count_q;
    assign err_irq   = err_irq_q;

endmodule
